vote_display_ctrl: RTL and testbench

Parametrised mode-control and display block for the voting machine. It sits between the vote-count registers and the board LEDs. In voting mode it flashes the LEDs for a fixed time after each valid vote. In result mode it shows a selected candidate's count or the current winner. It adds four things: a configurable candidate count, saturating count display, a retriggerable flash timer exposed as `busy`, and a sequential winner/tie scanner.

---
 rtl/vote_display_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_vote_display_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/vote_display_ctrl.sv
// Mode control and LED display for the voting machine: post-vote flash timer,
// candidate count / winner display, and a free-running sequential winner/tie scanner.
module vote_display_ctrl #(
  parameter int NUM_CAND     = 4,
  parameter int CNT_W        = 8,
  parameter int LED_W        = 8,
  parameter int FLASH_CYCLES = 100000000
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         mode,
  input  logic                         valid_vote_casted,
  input  logic [NUM_CAND*CNT_W-1:0]    vote_counts,
  input  logic [NUM_CAND-1:0]          button_press,
  input  logic                         winner_req,
  output logic [LED_W-1:0]             leds,
  output logic                         busy,
  output logic [$clog2(NUM_CAND)-1:0]  winner_idx,
  output logic                         tie
);

  localparam int IDX_W  = $clog2(NUM_CAND);
  localparam int CTR_W  = $clog2(FLASH_CYCLES + 1);
  localparam int WIDE_W = (CNT_W > LED_W) ? CNT_W : LED_W;
  localparam logic [CTR_W-1:0] CTR_MAX  = CTR_W'(FLASH_CYCLES);
  localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1);
  localparam logic [CTR_W-1:0] CTR_ZERO = CTR_W'(0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CAND - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_CAND = 2'd1,
    SEL_WIN  = 2'd2
  } sel_t;

  // Zero-extend a count to the LED bus, clamping to all ones when it does not fit.
  function automatic logic [LED_W-1:0] sat_count(input logic [CNT_W-1:0] c);
    logic [WIDE_W-1:0] wide;
    wide = WIDE_W'(c);
    if ((wide >> LED_W) != {WIDE_W{1'b0}}) begin
      sat_count = {LED_W{1'b1}};
    end else begin
      sat_count = wide[LED_W-1:0];
    end
  endfunction

  logic [CTR_W-1:0] counter;
  logic [CTR_W-1:0] counter_next;
  sel_t             sel;
  sel_t             sel_next;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] sel_idx_next;
  logic [LED_W-1:0] leds_next;
  logic [CNT_W-1:0] shown_count;
  logic             all_zero;
  logic [IDX_W-1:0] scan_k;
  logic [CNT_W-1:0] scan_max;
  logic [IDX_W-1:0] scan_win;
  logic             scan_dup;
  logic [CNT_W-1:0] scan_cur;
  logic [CNT_W-1:0] max_next;
  logic [IDX_W-1:0] win_next;
  logic             dup_next;

  // Flash timer: a vote in voting mode (re)loads 1, otherwise count up to FLASH_CYCLES then clear.
  always_comb begin
    counter_next = counter;
    if (!mode && valid_vote_casted) begin
      counter_next = CTR_ONE;
    end else if (counter == CTR_MAX) begin
      counter_next = CTR_ZERO;
    end else if (counter != CTR_ZERO) begin
      counter_next = counter + CTR_ONE;
    end else begin
      counter_next = counter;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      counter <= CTR_ZERO;
      busy    <= 1'b0;
    end else begin
      counter <= counter_next;
      busy    <= (counter_next != CTR_ZERO);
    end
  end

  // Display select: winner request beats buttons; lowest-index button wins.
  always_comb begin
    sel_next     = sel;
    sel_idx_next = sel_idx;
    if (!mode) begin
      sel_next     = SEL_NONE;
      sel_idx_next = IDX_ZERO;
    end else if (winner_req) begin
      sel_next = SEL_WIN;
    end else if (|button_press) begin
      sel_next = SEL_CAND;
      for (int i = NUM_CAND - 1; i >= 0; i--) begin
        sel_idx_next = button_press[i] ? IDX_W'(i) : sel_idx_next;
      end
    end else begin
      sel_next = sel;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sel     <= SEL_NONE;
      sel_idx <= IDX_ZERO;
    end else begin
      sel     <= sel_next;
      sel_idx <= sel_idx_next;
    end
  end

  assign shown_count = vote_counts[int'(sel_idx)*CNT_W +: CNT_W];
  assign all_zero    = ~|vote_counts;

  // LED content selection; the winner view blanks when nobody has a vote.
  always_comb begin
    leds_next = {LED_W{1'b0}};
    if (!mode) begin
      leds_next = busy ? {LED_W{1'b1}} : {LED_W{1'b0}};
    end else begin
      case (sel)
        SEL_CAND: leds_next = sat_count(shown_count);
        SEL_WIN: begin
          if (all_zero) begin
            leds_next = {LED_W{1'b0}};
          end else begin
            leds_next[IDX_W-1:0] = winner_idx + IDX_ONE;
            leds_next[LED_W-1]   = tie;
          end
        end
        default: leds_next = {LED_W{1'b0}};
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      leds <= {LED_W{1'b0}};
    end else begin
      leds <= leds_next;
    end
  end

  assign scan_cur = vote_counts[int'(scan_k)*CNT_W +: CNT_W];

  // One candidate per cycle; strict greater-than keeps the lowest index on ties.
  always_comb begin
    max_next = scan_max;
    win_next = scan_win;
    dup_next = scan_dup;
    if (scan_k == IDX_ZERO) begin
      max_next = scan_cur;
      win_next = IDX_ZERO;
      dup_next = 1'b0;
    end else if (scan_cur > scan_max) begin
      max_next = scan_cur;
      win_next = scan_k;
      dup_next = 1'b0;
    end else if (scan_cur == scan_max) begin
      dup_next = 1'b1;
    end else begin
      dup_next = scan_dup;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      scan_k     <= IDX_ZERO;
      scan_max   <= CNT_ZERO;
      scan_win   <= IDX_ZERO;
      scan_dup   <= 1'b0;
      winner_idx <= IDX_ZERO;
      tie        <= 1'b0;
    end else begin
      scan_max <= max_next;
      scan_win <= win_next;
      scan_dup <= dup_next;
      if (scan_k == IDX_LAST) begin
        scan_k     <= IDX_ZERO;
        winner_idx <= win_next;
        tie        <= dup_next && (max_next != CNT_ZERO);
      end else begin
        scan_k <= scan_k + IDX_ONE;
      end
    end
  end

endmodule

// File: tb/tb_vote_display_ctrl.sv
// Directed bench for vote_display_ctrl: flash timing, retrigger, selection,
// winner/tie scanning, saturation and mid-operation reset.
module tb_vote_display_ctrl;

  localparam int NC = 4;
  localparam int CW = 10;
  localparam int LW = 8;
  localparam int FC = 5;

  logic              clock;
  logic              reset;
  logic              mode;
  logic              valid_vote_casted;
  logic [NC*CW-1:0]  vote_counts;
  logic [NC-1:0]     button_press;
  logic              winner_req;
  logic [LW-1:0]     leds;
  logic              busy;
  logic [1:0]        winner_idx;
  logic              tie;

  int n_checks = 0;
  int n_fail   = 0;

  vote_display_ctrl #(
    .NUM_CAND(NC), .CNT_W(CW), .LED_W(LW), .FLASH_CYCLES(FC)
  ) dut (
    .clock(clock), .reset(reset), .mode(mode),
    .valid_vote_casted(valid_vote_casted), .vote_counts(vote_counts),
    .button_press(button_press), .winner_req(winner_req),
    .leds(leds), .busy(busy), .winner_idx(winner_idx), .tie(tie)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic set_counts(input int c0, input int c1, input int c2, input int c3);
    vote_counts = {CW'(c3), CW'(c2), CW'(c1), CW'(c0)};
  endtask

  // Pulse now, optionally pulse again at position p2; check busy/leds windows.
  task automatic flash_seq(input string tag, input int p2, input int busy_end,
                           input int led_end, input int n_max);
    valid_vote_casted = 1'b1;
    step(1);
    for (int n = 1; n <= n_max; n++) begin
      check({tag, "_busy"}, 32'(busy), 32'((n <= busy_end) ? 1 : 0));
      check({tag, "_leds"}, 32'(leds), (n >= 2 && n <= led_end) ? 32'hFF : 32'h00);
      valid_vote_casted = (n == p2);
      step(1);
    end
    valid_vote_casted = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    mode = 1'b0;
    valid_vote_casted = 1'b0;
    vote_counts = '0;
    button_press = '0;
    winner_req = 1'b0;
    step(2);
    check("rst_leds", 32'(leds), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_widx", 32'(winner_idx), 32'h0);
    check("rst_tie", 32'(tie), 32'h0);
    reset = 1'b0;
    step(1);

    flash_seq("flash", 0, 5, 6, 8);
    flash_seq("retrig", 3, 8, 9, 10);
    flash_seq("final_retrig", 5, 10, 11, 12);

    // Mode goes to result mid-flash: display blanks, timer keeps running
    valid_vote_casted = 1'b1;
    step(1);
    valid_vote_casted = 1'b0;
    mode = 1'b1;
    step(2);
    check("mode_flash_leds", 32'(leds), 32'h00);
    check("mode_flash_busy", 32'(busy), 32'h1);
    step(3);
    check("mode_flash_done", 32'(busy), 32'h0);
    valid_vote_casted = 1'b1;
    step(1);
    valid_vote_casted = 1'b0;
    check("vote_in_result", 32'(busy), 32'h0);
    step(1);
    check("vote_in_result2", 32'(busy), 32'h0);
    check("none_leds", 32'(leds), 32'h00);

    set_counts(12, 40, 7, 40);
    button_press = 4'b0100;
    step(2);
    check("sel_btn2", 32'(leds), 32'h07);
    button_press = 4'b1010;
    step(2);
    check("sel_btn13", 32'(leds), 32'h28);
    button_press = 4'b0000;
    step(2);
    check("sel_hold", 32'(leds), 32'h28);

    winner_req = 1'b1;
    button_press = 4'b0001;
    step(1);
    winner_req = 1'b0;
    button_press = 4'b0000;
    step(10);
    check("win_idx", 32'(winner_idx), 32'h1);
    check("win_tie", 32'(tie), 32'h1);
    check("win_leds", 32'(leds), 32'h82);

    set_counts(3, 5, 20, 1);
    step(10);
    check("win2_idx", 32'(winner_idx), 32'h2);
    check("win2_tie", 32'(tie), 32'h0);
    check("win2_leds", 32'(leds), 32'h03);

    set_counts(0, 0, 0, 0);
    step(10);
    check("zero_idx", 32'(winner_idx), 32'h0);
    check("zero_tie", 32'(tie), 32'h0);
    check("zero_leds", 32'(leds), 32'h00);

    mode = 1'b0;
    step(2);
    mode = 1'b1;
    step(2);
    check("back_to_none", 32'(leds), 32'h00);

    set_counts(300, 0, 0, 0);
    button_press = 4'b0001;
    step(2);
    check("sat_300", 32'(leds), 32'hFF);
    set_counts(256, 0, 0, 0);
    step(2);
    check("sat_256", 32'(leds), 32'hFF);
    set_counts(255, 0, 0, 0);
    step(2);
    check("sat_255", 32'(leds), 32'hFF);
    set_counts(200, 0, 0, 0);
    step(2);
    check("sat_200", 32'(leds), 32'hC8);
    button_press = 4'b0000;

    // Reset in the middle of a flash
    mode = 1'b0;
    set_counts(12, 40, 7, 40);
    valid_vote_casted = 1'b1;
    step(1);
    valid_vote_casted = 1'b0;
    step(1);
    check("pre_rst_busy", 32'(busy), 32'h1);
    check("pre_rst_leds", 32'(leds), 32'hFF);
    reset = 1'b1;
    step(1);
    check("mid_rst_leds", 32'(leds), 32'h00);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_widx", 32'(winner_idx), 32'h0);
    check("mid_rst_tie", 32'(tie), 32'h0);
    reset = 1'b0;
    mode = 1'b1;
    step(10);
    check("pre_scan_rst_idx", 32'(winner_idx), 32'h1);
    check("pre_scan_rst_tie", 32'(tie), 32'h1);
    reset = 1'b1;
    step(1);
    check("scan_rst_idx", 32'(winner_idx), 32'h0);
    check("scan_rst_tie", 32'(tie), 32'h0);
    check("scan_rst_leds", 32'(leds), 32'h00);
    reset = 1'b0;
    step(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
